// File: rtl/rx_multilane_block_decoder.sv
`default_nettype none
// ============================================================================
// Module   : rx_multilane_block_decoder
// Brief    : Multi-lane receive block decoder for 64b/66b (Gen2) and
//            128b/132b (Gen3) with Gen4 byte pass-through. Strips and checks
//            sync headers, serialises one byte per lane per cycle, and runs a
//            per-lane block-lock FSM that gates enable_deskew.
// Revision : 1.0 - initial release
// ============================================================================
module rx_multilane_block_decoder #(
    parameter int NUM_LANES  = 2,
    parameter int LOCK_CNT   = 4,
    parameter int ERR_THRESH = 3
) (
    input  logic                   enc_clk,
    input  logic                   rst,
    input  logic                   enable_dec,
    input  logic [1:0]             gen_speed,
    input  logic [3:0]             d_sel,
    input  logic [NUM_LANES*132-1:0] rx_enc,
    input  logic                   rx_enc_valid,
    output logic                   rx_enc_ready,
    output logic [NUM_LANES*8-1:0] lane_rx,
    output logic                   lane_rx_valid,
    output logic [NUM_LANES-1:0]   data_os,
    output logic [NUM_LANES-1:0]   sync_err,
    output logic [NUM_LANES-1:0]   block_lock,
    output logic                   enable_deskew
);

    localparam logic [1:0] c_GEN4       = 2'b00;
    localparam logic [1:0] c_GEN3       = 2'b01;
    localparam logic [1:0] c_GEN2       = 2'b10;
    localparam logic [1:0] c_RSVD       = 2'b11;
    localparam int         c_BLK_W      = 132;
    localparam logic [3:0] c_LOCK_CNT   = 4'(LOCK_CNT);
    localparam logic [3:0] c_ERR_THRESH = 4'(ERR_THRESH);
    // Gen4 has no header: lock is granted on the second accepted byte.
    localparam logic [3:0] c_GEN4_LOCK  = 4'd2;

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    logic [1:0]                     r_gen_q;
    logic                           w_spd_chg;
    logic                           w_run;
    logic                           w_flush;
    logic [3:0]                     w_last_idx;
    logic [7:0]                     w_hdr_off;
    logic                           r_active;
    logic [3:0]                     r_cnt;
    logic                           w_at_last;
    logic                           w_accept;
    logic [3:0]                     w_byte_idx;
    logic [7:0]                     w_byte_off;
    logic [NUM_LANES*c_BLK_W-1:0]   r_blk;
    logic [NUM_LANES*c_BLK_W-1:0]   w_src;
    logic [NUM_LANES*8-1:0]         w_bytes;
    logic [NUM_LANES-1:0]           w_hdr_ok;
    logic [NUM_LANES-1:0]           w_os_next;

    // A speed change is only meaningful while enabled; the registered copy
    // catches it for exactly one flush cycle.
    assign w_spd_chg = enable_dec & (gen_speed != r_gen_q);
    // Reset is folded in so that ready is low while rst is asserted.
    assign w_run     = rst & enable_dec & (gen_speed != c_RSVD) & ~w_spd_chg;
    assign w_flush   = ~w_run;

    // Per-speed block geometry: index of the last byte and header width.
    always_comb begin
        w_last_idx = 4'd0;
        w_hdr_off  = 8'd0;
        case (gen_speed)
            c_GEN2: begin
                w_last_idx = 4'd7;
                w_hdr_off  = 8'd2;
            end
            c_GEN3: begin
                w_last_idx = 4'd15;
                w_hdr_off  = 8'd4;
            end
            default: ;
        endcase
    end

    assign w_at_last    = (r_cnt == w_last_idx);
    assign rx_enc_ready = w_run & (~r_active | w_at_last);
    assign w_accept     = rx_enc_valid & rx_enc_ready;

    // On accept byte 0 comes straight from the input; otherwise the next byte
    // of the captured block is selected.
    assign w_byte_idx = w_accept ? 4'd0 : (r_cnt + 4'd1);
    assign w_byte_off = w_hdr_off + {1'b0, w_byte_idx, 3'b000};
    assign w_src      = w_accept ? rx_enc : r_blk;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [c_BLK_W-1:0] w_lane_blk;
        logic [3:0]         w_hdr;
        logic               w_ok;
        logic               w_os;
        logic [3:0]         w_lock_tgt;
        lock_state_t        r_state;
        lock_state_t        w_state_nxt;
        logic [3:0]         r_good;
        logic [3:0]         r_bad;
        logic [3:0]         w_good_nxt;
        logic [3:0]         w_bad_nxt;

        assign w_lane_blk           = w_src[i*c_BLK_W +: c_BLK_W];
        assign w_bytes[i*8 +: 8]    = w_lane_blk[w_byte_off +: 8];
        assign w_hdr                = rx_enc[i*c_BLK_W +: 4];

        // Classify the sync header of the block being offered.
        always_comb begin
            w_ok = 1'b0;
            w_os = 1'b0;
            case (gen_speed)
                c_GEN2: begin
                    w_ok = (w_hdr[1:0] == 2'b01) | (w_hdr[1:0] == 2'b10);
                    w_os = (w_hdr[1:0] == 2'b10);
                end
                c_GEN3: begin
                    w_ok = (w_hdr == 4'b0101) | (w_hdr == 4'b1010);
                    w_os = (w_hdr == 4'b1010);
                end
                c_GEN4: begin
                    w_ok = 1'b1;
                    w_os = (d_sel == 4'h8);
                end
                default: ;
            endcase
        end

        assign w_hdr_ok[i]  = w_ok;
        // An invalid header keeps the previous block type.
        assign w_os_next[i] = w_ok ? w_os : data_os[i];
        assign w_lock_tgt   = (gen_speed == c_GEN4) ? c_GEN4_LOCK : c_LOCK_CNT;

        // Lock FSM next state, evaluated once per accepted block.
        always_comb begin
            w_state_nxt = r_state;
            w_good_nxt  = r_good;
            w_bad_nxt   = r_bad;
            if (w_flush) begin
                w_state_nxt = ST_UNLOCKED;
                w_good_nxt  = 4'd0;
                w_bad_nxt   = 4'd0;
            end else if (w_accept) begin
                case (r_state)
                    ST_UNLOCKED: begin
                        if (w_ok) begin
                            if ((r_good + 4'd1) == w_lock_tgt) begin
                                w_state_nxt = ST_LOCKED;
                                w_good_nxt  = 4'd0;
                            end else begin
                                w_good_nxt = r_good + 4'd1;
                            end
                        end else begin
                            w_good_nxt = 4'd0;
                        end
                    end
                    default: begin
                        if (!w_ok) begin
                            if ((r_bad + 4'd1) == c_ERR_THRESH) begin
                                w_state_nxt = ST_UNLOCKED;
                                w_good_nxt  = 4'd0;
                                w_bad_nxt   = 4'd0;
                            end else begin
                                w_bad_nxt = r_bad + 4'd1;
                            end
                        end else begin
                            w_bad_nxt = 4'd0;
                        end
                    end
                endcase
            end
        end

        // Lock FSM state and counter registers.
        always_ff @(posedge enc_clk or negedge rst) begin
            if (!rst) begin
                r_state <= ST_UNLOCKED;
                r_good  <= 4'd0;
                r_bad   <= 4'd0;
            end else begin
                r_state <= w_state_nxt;
                r_good  <= w_good_nxt;
                r_bad   <= w_bad_nxt;
            end
        end

        assign block_lock[i] = (r_state == ST_LOCKED);
    end

    // Registered copy of gen_speed for change detection.
    always_ff @(posedge enc_clk or negedge rst) begin
        if (!rst) begin
            r_gen_q <= c_GEN4;
        end else begin
            r_gen_q <= gen_speed;
        end
    end

    // Block capture and byte serialiser; flush keeps lane_rx and data_os.
    always_ff @(posedge enc_clk or negedge rst) begin
        if (!rst) begin
            r_blk         <= '0;
            r_active      <= 1'b0;
            r_cnt         <= 4'd0;
            lane_rx       <= '0;
            lane_rx_valid <= 1'b0;
            data_os       <= '0;
            sync_err      <= '0;
        end else if (w_flush) begin
            r_active      <= 1'b0;
            r_cnt         <= 4'd0;
            lane_rx_valid <= 1'b0;
            sync_err      <= '0;
        end else if (w_accept) begin
            r_blk         <= rx_enc;
            r_active      <= 1'b1;
            r_cnt         <= 4'd0;
            lane_rx       <= w_bytes;
            lane_rx_valid <= 1'b1;
            data_os       <= w_os_next;
            sync_err      <= ~w_hdr_ok;
        end else if (r_active && !w_at_last) begin
            r_cnt         <= r_cnt + 4'd1;
            lane_rx       <= w_bytes;
            lane_rx_valid <= 1'b1;
            sync_err      <= '0;
        end else begin
            r_active      <= 1'b0;
            r_cnt         <= 4'd0;
            lane_rx_valid <= 1'b0;
            sync_err      <= '0;
        end
    end

    // Deskew is enabled one cycle after every lane reports lock.
    always_ff @(posedge enc_clk or negedge rst) begin
        if (!rst) begin
            enable_deskew <= 1'b0;
        end else if (w_flush) begin
            enable_deskew <= 1'b0;
        end else begin
            enable_deskew <= &block_lock;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_multilane_block_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_multilane_block_decoder
// Brief    : Self-checking bench for rx_multilane_block_decoder (2 lanes,
//            LOCK_CNT=4, ERR_THRESH=3): Gen2 streaming, Gen3 lock/unlock
//            vector table, Gen4 pass-through, flush and async reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_multilane_block_decoder;

    localparam int         NL = 2;
    localparam logic [1:0] G4 = 2'b00;
    localparam logic [1:0] G3 = 2'b01;
    localparam logic [1:0] G2 = 2'b10;

    logic              enc_clk      = 1'b0;
    logic              rst          = 1'b0;
    logic              enable_dec   = 1'b0;
    logic [1:0]        gen_speed    = G2;
    logic [3:0]        d_sel        = 4'h0;
    logic [NL*132-1:0] rx_enc       = '0;
    logic              rx_enc_valid = 1'b0;
    logic              rx_enc_ready;
    logic [NL*8-1:0]   lane_rx;
    logic              lane_rx_valid;
    logic [NL-1:0]     data_os;
    logic [NL-1:0]     sync_err;
    logic [NL-1:0]     block_lock;
    logic              enable_deskew;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] h0;
        logic [3:0] h1;
        logic [1:0] os;
        logic [1:0] err;
        logic [1:0] lock;
        logic       desk0;
        logic       desk1;
    } g3_vec_t;

    g3_vec_t tbl [12];

    rx_multilane_block_decoder #(
        .NUM_LANES  (NL),
        .LOCK_CNT   (4),
        .ERR_THRESH (3)
    ) dut (
        .enc_clk       (enc_clk),
        .rst           (rst),
        .enable_dec    (enable_dec),
        .gen_speed     (gen_speed),
        .d_sel         (d_sel),
        .rx_enc        (rx_enc),
        .rx_enc_valid  (rx_enc_valid),
        .rx_enc_ready  (rx_enc_ready),
        .lane_rx       (lane_rx),
        .lane_rx_valid (lane_rx_valid),
        .data_os       (data_os),
        .sync_err      (sync_err),
        .block_lock    (block_lock),
        .enable_deskew (enable_deskew)
    );

    always #5 enc_clk = ~enc_clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge enc_clk);
        #1;
    endtask

    // Gen2/Gen3 lane block: header in the low bits, byte k = seed + k.
    function automatic logic [131:0] mk_blk(input logic [1:0] gen, input logic [3:0] hdr,
                                            input logic [7:0] seed);
        logic [131:0] b;
        b = '0;
        if (gen == G2) begin
            b[1:0] = hdr[1:0];
            for (int k = 0; k < 8; k++) b[2+8*k +: 8] = seed + 8'(k);
        end else begin
            b[3:0] = hdr;
            for (int k = 0; k < 16; k++) b[4+8*k +: 8] = seed + 8'(k);
        end
        return b;
    endfunction

    // Gen4 lane word: upper bits set so any stray header logic would misfire.
    function automatic logic [131:0] mk_g4(input logic [7:0] v);
        logic [131:0] b;
        b      = '1;
        b[7:0] = v;
        return b;
    endfunction

    function automatic logic [15:0] exp_pair(input logic [7:0] s0, input logic [7:0] s1,
                                             input int k);
        return {s1 + 8'(k), s0 + 8'(k)};
    endfunction

    initial begin
        logic [7:0] s0;
        logic [7:0] s1;

        //             h0       h1       os     err    lock   d0    d1
        tbl[0]  = '{4'b0101, 4'b0101, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[1]  = '{4'b1010, 4'b1010, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[2]  = '{4'b0101, 4'b0101, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[3]  = '{4'b0101, 4'b1010, 2'b10, 2'b00, 2'b11, 1'b0, 1'b1};
        tbl[4]  = '{4'b0101, 4'b0000, 2'b10, 2'b10, 2'b11, 1'b1, 1'b1};
        tbl[5]  = '{4'b0101, 4'b0000, 2'b10, 2'b10, 2'b11, 1'b1, 1'b1};
        tbl[6]  = '{4'b0101, 4'b0000, 2'b10, 2'b10, 2'b01, 1'b1, 1'b0};
        tbl[7]  = '{4'b0101, 4'b0101, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0};
        tbl[8]  = '{4'b0011, 4'b0101, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0};
        tbl[9]  = '{4'b0101, 4'b0101, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0};
        tbl[10] = '{4'b1111, 4'b0101, 2'b00, 2'b01, 2'b11, 1'b0, 1'b1};
        tbl[11] = '{4'b1111, 4'b1010, 2'b10, 2'b01, 2'b11, 1'b1, 1'b1};

        // ---------------- reset state (enable and valid driven high) ----------
        rst          = 1'b0;
        enable_dec   = 1'b1;
        rx_enc_valid = 1'b1;
        rx_enc       = {mk_blk(G2, 4'b0001, 8'h11), mk_blk(G2, 4'b0001, 8'h01)};
        repeat (2) @(posedge enc_clk);
        #1;
        chk("rst_ready", rx_enc_ready, 1'b0);
        chk("rst_lane_rx", lane_rx, 16'h0);
        chk("rst_valid", lane_rx_valid, 1'b0);
        chk("rst_data_os", data_os, 2'b00);
        chk("rst_sync_err", sync_err, 2'b00);
        chk("rst_block_lock", block_lock, 2'b00);
        chk("rst_deskew", enable_deskew, 1'b0);
        enable_dec   = 1'b0;
        rx_enc_valid = 1'b0;
        @(negedge enc_clk);
        rst = 1'b1;
        step();
        step();

        // ---------------- Gen2 streaming, then valid dropped -----------------
        enable_dec   = 1'b1;
        rx_enc_valid = 1'b1;
        #1;
        chk("g2_ready_c0", rx_enc_ready, 1'b1);
        for (int b = 0; b < 2; b++) begin
            s0 = (b == 0) ? 8'h01 : 8'h21;
            s1 = (b == 0) ? 8'h11 : 8'h31;
            step();
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("g2_b%0d_k%0d_valid", b, k), lane_rx_valid, 1'b1);
                chk($sformatf("g2_b%0d_k%0d_data", b, k), lane_rx, exp_pair(s0, s1, k));
                chk($sformatf("g2_b%0d_k%0d_ready", b, k), rx_enc_ready, (k == 7));
                chk($sformatf("g2_b%0d_k%0d_os", b, k), data_os, (b == 0) ? 2'b00 : 2'b11);
                if (k == 0) chk($sformatf("g2_b%0d_err", b), sync_err, 2'b00);
                if (k == 7) begin
                    if (b == 0) rx_enc = {mk_blk(G2, 4'b0010, 8'h31), mk_blk(G2, 4'b0010, 8'h21)};
                    else        rx_enc_valid = 1'b0;
                end else begin
                    step();
                end
            end
        end
        step();
        chk("g2_drop_valid", lane_rx_valid, 1'b0);
        chk("g2_drop_hold", lane_rx, 16'h3828);
        chk("g2_drop_ready", rx_enc_ready, 1'b1);
        chk("g2_drop_lock", block_lock, 2'b00);

        // ---------------- Gen3 lock / unlock vector table --------------------
        enable_dec = 1'b0;
        gen_speed  = G3;
        step();
        step();
        enable_dec = 1'b1;
        for (int r = 0; r < 12; r++) begin
            s0 = 8'(r * 16);
            s1 = 8'(8'h80 + r * 16);
            rx_enc       = {mk_blk(G3, tbl[r].h1, s1), mk_blk(G3, tbl[r].h0, s0)};
            rx_enc_valid = 1'b1;
            #1;
            chk($sformatf("g3_r%0d_ready", r), rx_enc_ready, 1'b1);
            step();
            for (int k = 0; k < 16; k++) begin
                chk($sformatf("g3_r%0d_k%0d_valid", r, k), lane_rx_valid, 1'b1);
                chk($sformatf("g3_r%0d_k%0d_data", r, k), lane_rx, exp_pair(s0, s1, k));
                chk($sformatf("g3_r%0d_k%0d_ready", r, k), rx_enc_ready, (k == 15));
                if (k == 0) begin
                    chk($sformatf("g3_r%0d_os", r), data_os, tbl[r].os);
                    chk($sformatf("g3_r%0d_err", r), sync_err, tbl[r].err);
                    chk($sformatf("g3_r%0d_lock", r), block_lock, tbl[r].lock);
                    chk($sformatf("g3_r%0d_desk0", r), enable_deskew, tbl[r].desk0);
                end
                if (k == 1) begin
                    chk($sformatf("g3_r%0d_err_k1", r), sync_err, 2'b00);
                    chk($sformatf("g3_r%0d_desk1", r), enable_deskew, tbl[r].desk1);
                end
                if (k < 15) step();
            end
        end

        // ---------------- enable_dec dropped at byte 5 of a Gen3 block -------
        rx_enc = {mk_blk(G3, 4'b0101, 8'hC0), mk_blk(G3, 4'b0101, 8'h40)};
        step();
        rx_enc_valid = 1'b0;
        chk("fl_pre_lock", block_lock, 2'b11);
        chk("fl_pre_desk", enable_deskew, 1'b1);
        repeat (5) step();
        chk("fl_byte5", lane_rx, 16'hC545);
        enable_dec   = 1'b0;
        rx_enc_valid = 1'b1;
        #1;
        chk("fl_ready", rx_enc_ready, 1'b0);
        step();
        chk("fl_valid", lane_rx_valid, 1'b0);
        chk("fl_hold", lane_rx, 16'hC545);
        chk("fl_lock", block_lock, 2'b00);
        chk("fl_desk", enable_deskew, 1'b0);
        chk("fl_err", sync_err, 2'b00);
        rx_enc_valid = 1'b0;

        // ---------------- Gen4 pass-through, d_sel 8,0,8 ---------------------
        gen_speed = G4;
        step();
        step();
        enable_dec   = 1'b1;
        rx_enc_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            d_sel  = (j == 1) ? 4'h0 : 4'h8;
            rx_enc = {mk_g4(8'hB1 + 8'(j)), mk_g4(8'hA1 + 8'(j))};
            #1;
            chk($sformatf("g4_j%0d_ready", j), rx_enc_ready, 1'b1);
            step();
            chk($sformatf("g4_j%0d_data", j), lane_rx, {8'hB1 + 8'(j), 8'hA1 + 8'(j)});
            chk($sformatf("g4_j%0d_valid", j), lane_rx_valid, 1'b1);
            chk($sformatf("g4_j%0d_os", j), data_os, (j == 1) ? 2'b00 : 2'b11);
            chk($sformatf("g4_j%0d_lock", j), block_lock, (j == 0) ? 2'b00 : 2'b11);
            chk($sformatf("g4_j%0d_err", j), sync_err, 2'b00);
            chk($sformatf("g4_j%0d_desk", j), enable_deskew, (j == 2));
        end
        rx_enc_valid = 1'b0;
        step();
        chk("g4_idle_valid", lane_rx_valid, 1'b0);
        chk("g4_idle_hold", lane_rx, 16'hB3A3);

        // ---------------- gen_speed change while enabled ---------------------
        gen_speed    = G2;
        rx_enc       = {mk_blk(G2, 4'b0001, 8'h70), mk_blk(G2, 4'b0001, 8'h60)};
        rx_enc_valid = 1'b1;
        #1;
        chk("sc_ready_blocked", rx_enc_ready, 1'b0);
        step();
        chk("sc_valid", lane_rx_valid, 1'b0);
        chk("sc_lock", block_lock, 2'b00);
        chk("sc_desk", enable_deskew, 1'b0);
        chk("sc_ready_after", rx_enc_ready, 1'b1);

        // Gen2 lock after four valid blocks, then async reset mid-block.
        for (int b = 1; b <= 4; b++) begin
            step();
            chk($sformatf("g2l_b%0d_lock", b), block_lock, (b == 4) ? 2'b11 : 2'b00);
            chk($sformatf("g2l_b%0d_data", b), lane_rx, 16'h7060);
            if (b < 4) repeat (7) step();
        end
        rx_enc_valid = 1'b0;
        repeat (3) step();
        chk("rm_byte3", lane_rx, 16'h7363);
        #1;
        rst = 1'b0;
        #2;
        chk("rm_ready", rx_enc_ready, 1'b0);
        chk("rm_lane_rx", lane_rx, 16'h0);
        chk("rm_valid", lane_rx_valid, 1'b0);
        chk("rm_data_os", data_os, 2'b00);
        chk("rm_sync_err", sync_err, 2'b00);
        chk("rm_lock", block_lock, 2'b00);
        chk("rm_desk", enable_deskew, 1'b0);
        @(negedge enc_clk);
        rst = 1'b1;
        step();
        chk("rm_post1_valid", lane_rx_valid, 1'b0);
        step();
        chk("rm_post2_valid", lane_rx_valid, 1'b0);
        chk("rm_post2_lock", block_lock, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
